// File: rtl/acc_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared types and constants for the accumulator register
//                stage: FSM state encoding, shift-mode encoding and default
//                widths.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int ACC_W = 8;   // accumulator / data width
    localparam int SH_W  = 3;   // shift-amount field width

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } acc_state_t;

    typedef enum logic [1:0] {
        SH_LOG = 2'd0,          // logical
        SH_ARI = 2'd1,          // arithmetic (right only; left behaves as logical)
        SH_ROT = 2'd2,          // rotate
        SH_RTC = 2'd3           // rotate through carry
    } sh_mode_t;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/acc_shift1.sv
`default_nettype none
// ============================================================================
//  Module      : acc_shift1
//  Description : Purely combinational single-bit shifter/rotator for the
//                accumulator. Produces the accumulator and carry values after
//                one shift step in the requested direction and mode.
//  Ports       : acc        - current accumulator
//                carry      - current carry flag
//                dir        - 0 = left, 1 = right
//                mode       - shift mode (logical/arith/rotate/rotate-thru-C)
//                acc_next   - accumulator after one step
//                carry_next - carry after one step (the bit shifted out)
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_shift1
    import acc_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [W-1:0] acc,
    input  logic         carry,
    input  logic         dir,
    input  sh_mode_t     mode,
    output logic [W-1:0] acc_next,
    output logic         carry_next
);

    logic w_fill;

    always_comb begin
        w_fill     = 1'b0;
        acc_next   = acc;
        carry_next = carry;
        if (!dir) begin
            // Left: MSB leaves into carry, fill enters at bit 0.
            // Arithmetic left is identical to logical left.
            case (mode)
                SH_ROT:  w_fill = acc[W-1];
                SH_RTC:  w_fill = carry;
                default: w_fill = 1'b0;
            endcase
            carry_next = acc[W-1];
            acc_next   = {acc[W-2:0], w_fill};
        end else begin
            // Right: LSB leaves into carry, fill enters at the MSB.
            case (mode)
                SH_ARI:  w_fill = acc[W-1];
                SH_ROT:  w_fill = acc[0];
                SH_RTC:  w_fill = carry;
                default: w_fill = 1'b0;
            endcase
            carry_next = acc[0];
            acc_next   = {w_fill, acc[W-1:1]};
        end
    end

endmodule : acc_shift1
`default_nettype wire

// File: rtl/acc_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_shift_reg
//  Description : CPU accumulator register stage. Loads from the LUT constant,
//                data memory or ALU (fixed priority), performs multi-cycle
//                shift/rotate one bit per clock with a busy/done handshake,
//                and provides carry/zero/negative flags.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                lut_ld / lut_value       - load from accumulator LUT
//                mem_ld / mem_data        - load from data memory
//                alu_ld / alu_result /
//                alu_carry                - load from ALU (also writes carry)
//                sh_start / sh_dir /
//                sh_mode / sh_amt         - shift request
//                acc, carry, zero, neg    - accumulator and flags
//                busy                     - shift in progress
//                done                     - one-cycle pulse at shift end
//                ld_err                   - one-cycle pulse, request dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_shift_reg
    import acc_pkg::*;
#(
    parameter int W   = ACC_W,
    parameter int SHW = SH_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           lut_ld,
    input  logic [W-1:0]   lut_value,
    input  logic           mem_ld,
    input  logic [W-1:0]   mem_data,
    input  logic           alu_ld,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_carry,
    input  logic           sh_start,
    input  logic           sh_dir,
    input  logic [1:0]     sh_mode,
    input  logic [SHW-1:0] sh_amt,
    output logic [W-1:0]   acc,
    output logic           carry,
    output logic           zero,
    output logic           neg,
    output logic           busy,
    output logic           done,
    output logic           ld_err
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    acc_state_t     r_state;
    logic [W-1:0]   r_acc;
    logic           r_carry;
    logic [SHW-1:0] r_count;
    logic           r_dir;
    sh_mode_t       r_mode;
    logic           r_last;     // final shift step happened on the last edge
    logic           r_done;
    logic           r_ld_err;

    acc_state_t     w_state_nx;
    logic [W-1:0]   w_acc_nx;
    logic           w_carry_nx;
    logic [SHW-1:0] w_count_nx;
    logic           w_dir_nx;
    sh_mode_t       w_mode_nx;
    logic           w_last_nx;
    logic           w_done_nx;
    logic           w_ld_err_nx;

    logic [W-1:0]   w_sh_acc;
    logic           w_sh_carry;

    // ------------------------------------------------------------------
    // Single-step shifter, driven by the latched direction/mode
    // ------------------------------------------------------------------
    acc_shift1 #(
        .W (W)
    ) u_shift1 (
        .acc        (r_acc),
        .carry      (r_carry),
        .dir        (r_dir),
        .mode       (r_mode),
        .acc_next   (w_sh_acc),
        .carry_next (w_sh_carry)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_acc_nx    = r_acc;
        w_carry_nx  = r_carry;
        w_count_nx  = r_count;
        w_dir_nx    = r_dir;
        w_mode_nx   = r_mode;
        w_last_nx   = 1'b0;
        // done follows the final shift step by one cycle, so an N-bit shift
        // reports completion N+1 edges after it was accepted.
        w_done_nx   = r_last;
        w_ld_err_nx = 1'b0;

        case (r_state)
            IDLE: begin
                if (lut_ld) begin
                    w_acc_nx    = lut_value;
                    w_ld_err_nx = mem_ld | alu_ld | sh_start;
                end else if (mem_ld) begin
                    w_acc_nx    = mem_data;
                    w_ld_err_nx = alu_ld | sh_start;
                end else if (alu_ld) begin
                    w_acc_nx    = alu_result;
                    w_carry_nx  = alu_carry;
                    w_ld_err_nx = sh_start;
                end else if (sh_start) begin
                    if (sh_amt != '0) begin
                        // Accepting edge only latches the request; the first
                        // bit moves on the following edge.
                        w_state_nx = SHIFT;
                        w_dir_nx   = sh_dir;
                        w_mode_nx  = sh_mode_t'(sh_mode);
                        w_count_nx = sh_amt;
                    end else begin
                        // Zero-length shift completes immediately.
                        w_done_nx = 1'b1;
                    end
                end
            end

            SHIFT: begin
                w_acc_nx    = w_sh_acc;
                w_carry_nx  = w_sh_carry;
                w_count_nx  = r_count - SHW'(1);
                w_ld_err_nx = lut_ld | mem_ld | alu_ld | sh_start;
                if (r_count == SHW'(1)) begin
                    w_state_nx = IDLE;
                    w_last_nx  = 1'b1;
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_dir    <= 1'b0;
            r_mode   <= SH_LOG;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_acc    <= w_acc_nx;
            r_carry  <= w_carry_nx;
            r_count  <= w_count_nx;
            r_dir    <= w_dir_nx;
            r_mode   <= w_mode_nx;
            r_last   <= w_last_nx;
            r_done   <= w_done_nx;
            r_ld_err <= w_ld_err_nx;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign acc    = r_acc;
    assign carry  = r_carry;
    assign zero   = (r_acc == '0);
    assign neg    = r_acc[W-1];
    assign busy   = (r_state == SHIFT);
    assign done   = r_done;
    assign ld_err = r_ld_err;

endmodule : acc_shift_reg
`default_nettype wire

// File: tb/tb_acc_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_shift_reg
//  Description : Directed self-checking bench for acc_shift_reg. Inputs are
//                driven and outputs sampled 1 time unit after each rising
//                edge; expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lut_ld;
    logic [7:0] lut_value;
    logic       mem_ld;
    logic [7:0] mem_data;
    logic       alu_ld;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       sh_start;
    logic       sh_dir;
    logic [1:0] sh_mode;
    logic [2:0] sh_amt;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
    logic       neg;
    logic       busy;
    logic       done;
    logic       ld_err;

    int n_total = 0;
    int n_pass  = 0;

    acc_shift_reg #(
        .W   (8),
        .SHW (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lut_ld     (lut_ld),
        .lut_value  (lut_value),
        .mem_ld     (mem_ld),
        .mem_data   (mem_data),
        .alu_ld     (alu_ld),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .sh_start   (sh_start),
        .sh_dir     (sh_dir),
        .sh_mode    (sh_mode),
        .sh_amt     (sh_amt),
        .acc        (acc),
        .carry      (carry),
        .zero       (zero),
        .neg        (neg),
        .busy       (busy),
        .done       (done),
        .ld_err     (ld_err)
    );

    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short; anything beyond this is a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        lut_ld   = 1'b0;
        mem_ld   = 1'b0;
        alu_ld   = 1'b0;
        sh_start = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        lut_value  = 8'h00;
        mem_data   = 8'h00;
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        sh_dir     = 1'b0;
        sh_mode    = 2'd0;
        sh_amt     = 3'd0;
        clear_strobes();

        // ---------------- reset state ----------------
        step(); step();
        check("rst_acc",    32'(acc),    32'h00);
        check("rst_carry",  32'(carry),  32'h0);
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_done",   32'(done),   32'h0);
        check("rst_ld_err", 32'(ld_err), 32'h0);
        check("rst_zero",   32'(zero),   32'h1);
        check("rst_neg",    32'(neg),    32'h0);
        rst_n = 1'b1;
        step();

        // ---------------- LUT wins over memory ----------------
        lut_ld = 1'b1; lut_value = 8'h40;
        mem_ld = 1'b1; mem_data  = 8'h11;
        step(); clear_strobes();
        check("lut_pri_acc",    32'(acc),    32'h40);
        check("lut_pri_ld_err", 32'(ld_err), 32'h1);
        check("lut_pri_carry",  32'(carry),  32'h0);
        step();
        check("lut_pri_ld_err_clr", 32'(ld_err), 32'h0);

        // ---------------- ALU load writes carry ----------------
        alu_ld = 1'b1; alu_result = 8'h00; alu_carry = 1'b1;
        step(); clear_strobes();
        check("alu_acc",    32'(acc),    32'h00);
        check("alu_carry",  32'(carry),  32'h1);
        check("alu_zero",   32'(zero),   32'h1);
        check("alu_ld_err", 32'(ld_err), 32'h0);

        // ---------------- memory load keeps carry ----------------
        mem_ld = 1'b1; mem_data = 8'h81;
        step(); clear_strobes();
        check("mem_acc",   32'(acc),   32'h81);
        check("mem_carry", 32'(carry), 32'h1);
        check("mem_neg",   32'(neg),   32'h1);

        // ---------------- logical left by 3 on 0x81 ----------------
        sh_start = 1'b1; sh_dir = 1'b0; sh_mode = 2'd0; sh_amt = 3'd3;
        step(); clear_strobes();
        check("lsl_accept_busy", 32'(busy), 32'h1);
        check("lsl_accept_acc",  32'(acc),  32'h81);
        step();
        check("lsl_s1_acc",   32'(acc),   32'h02);
        check("lsl_s1_carry", 32'(carry), 32'h1);
        check("lsl_s1_busy",  32'(busy),  32'h1);
        step();
        check("lsl_s2_acc",   32'(acc),   32'h04);
        check("lsl_s2_carry", 32'(carry), 32'h0);
        check("lsl_s2_busy",  32'(busy),  32'h1);
        step();
        check("lsl_s3_acc",   32'(acc),   32'h08);
        check("lsl_s3_carry", 32'(carry), 32'h0);
        check("lsl_s3_busy",  32'(busy),  32'h0);
        check("lsl_s3_done",  32'(done),  32'h0);
        step();
        check("lsl_done",     32'(done),  32'h1);
        step();
        check("lsl_done_clr", 32'(done),  32'h0);

        // ---------------- arithmetic right by 2, load dropped ----------------
        lut_ld = 1'b1; lut_value = 8'h80;
        step(); clear_strobes();
        check("asr_load_acc", 32'(acc), 32'h80);
        sh_start = 1'b1; sh_dir = 1'b1; sh_mode = 2'd1; sh_amt = 3'd2;
        step(); clear_strobes();
        check("asr_accept_busy", 32'(busy), 32'h1);
        lut_ld = 1'b1; lut_value = 8'h55;
        step(); clear_strobes();
        check("asr_s1_acc",    32'(acc),    32'hC0);
        check("asr_s1_ld_err", 32'(ld_err), 32'h1);
        step();
        check("asr_s2_acc",    32'(acc),    32'hE0);
        check("asr_s2_carry",  32'(carry),  32'h0);
        check("asr_s2_neg",    32'(neg),    32'h1);
        check("asr_s2_busy",   32'(busy),   32'h0);
        check("asr_s2_ld_err", 32'(ld_err), 32'h0);
        step();
        check("asr_done", 32'(done), 32'h1);
        check("asr_acc_kept", 32'(acc), 32'hE0);

        // ---------------- rotate-through-carry left by 1 ----------------
        alu_ld = 1'b1; alu_result = 8'h00; alu_carry = 1'b1;
        step(); clear_strobes();
        sh_start = 1'b1; sh_dir = 1'b0; sh_mode = 2'd3; sh_amt = 3'd1;
        step(); clear_strobes();
        check("rtc_accept_busy", 32'(busy), 32'h1);
        step();
        check("rtc_acc",   32'(acc),   32'h01);
        check("rtc_carry", 32'(carry), 32'h0);
        check("rtc_busy",  32'(busy),  32'h0);
        step();
        check("rtc_done", 32'(done), 32'h1);
        step();
        check("rtc_done_clr", 32'(done), 32'h0);

        // ---------------- zero-length shift ----------------
        sh_start = 1'b1; sh_dir = 1'b0; sh_mode = 2'd3; sh_amt = 3'd0;
        step(); clear_strobes();
        check("amt0_done", 32'(done), 32'h1);
        check("amt0_busy", 32'(busy), 32'h0);
        check("amt0_acc",  32'(acc),  32'h01);
        step();
        check("amt0_done_clr", 32'(done), 32'h0);
        check("amt0_busy2",    32'(busy), 32'h0);

        // ---------------- rotate right by 1 ----------------
        sh_start = 1'b1; sh_dir = 1'b1; sh_mode = 2'd2; sh_amt = 3'd1;
        step(); clear_strobes();
        step();
        check("ror_acc",   32'(acc),   32'h80);
        check("ror_carry", 32'(carry), 32'h1);

        // ---------------- async reset in the middle of a shift ----------------
        mem_ld = 1'b1; mem_data = 8'h81;
        step(); clear_strobes();
        sh_start = 1'b1; sh_dir = 1'b0; sh_mode = 2'd0; sh_amt = 3'd7;
        step(); clear_strobes();
        step();
        check("pre_rst_acc",   32'(acc),   32'h02);
        check("pre_rst_carry", 32'(carry), 32'h1);
        check("pre_rst_busy",  32'(busy),  32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_acc",   32'(acc),   32'h00);
        check("arst_carry", 32'(carry), 32'h0);
        check("arst_busy",  32'(busy),  32'h0);
        check("arst_zero",  32'(zero),  32'h1);
        check("arst_neg",   32'(neg),   32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_acc",  32'(acc),  32'h00);
        check("post_rst_done", 32'(done), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_acc_shift_reg
`default_nettype wire

// File: doc/acc_shift_reg.md
Name: acc_shift_reg

Overview:
- Accumulator register stage directly downstream of the accumulator constant LUT (5-bit key -> 8-bit constant).
- Holds the CPU accumulator and loads it from one of three sources: LUT constant, ALU result or data-memory read.
- Performs multi-cycle shift/rotate, one bit per clock, with a busy/done handshake to the controller.
- Produces carry, zero and negative flags for branch decode.

Parameters:
- W, 8, accumulator and data width
- SHW, 3, width of shift-amount field (max shift 2**SHW-1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- lut_ld  in  1  load acc from lut_value
- lut_value  in  W  constant from accumulator LUT
- mem_ld  in  1  load acc from mem_data
- mem_data  in  W  data-memory read data
- alu_ld  in  1  load acc from alu_result, carry from alu_carry
- alu_result  in  W  ALU output
- alu_carry  in  1  ALU carry-out
- sh_start  in  1  start shift operation
- sh_dir  in  1  0 = left, 1 = right
- sh_mode  in  2  0 logical, 1 arithmetic (right only; left = logical), 2 rotate, 3 rotate-through-carry
- sh_amt  in  SHW  number of bit positions
- acc  out  W  accumulator value
- carry  out  1  carry flag
- zero  out  1  combinational, acc == 0
- neg  out  1  combinational, acc[W-1]
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse at shift completion
- ld_err  out  1  one-cycle pulse: load/start request dropped

Behaviour:
- Single clock; asynchronous active-low reset.
- Reset (asynchronous, any state, including mid-shift): acc=0, carry=0, busy=0, done=0, ld_err=0, state=IDLE, count=0. Consequently zero=1 and neg=0.
- States:
  - IDLE: accepts loads and sh_start.
  - SHIFT: shifting; busy=1. busy is a registered state decode.
- Loads in IDLE take effect at the next rising edge.
  - Priority when several strobes are high: lut_ld > mem_ld > alu_ld > sh_start.
  - Losers are dropped and ld_err pulses for one cycle.
  - lut_ld and mem_ld leave carry unchanged; alu_ld writes carry=alu_carry.
- sh_start in IDLE:
  - sh_amt > 0: latch dir, mode and count=sh_amt; go to SHIFT. No shift occurs on the accepting edge.
  - sh_amt == 0: stay in IDLE, acc and carry unchanged, done=1 next cycle.
- SHIFT, on each edge:
  - Perform one 1-bit shift and decrement count.
  - When count==1: go to IDLE and pulse done=1 in the following cycle. An N-bit shift asserts done N+1 edges after the accepting edge.
- 1-bit shift rules:
  - Left: carry <= acc[W-1]. Fill bit acc[0] <= 0 (logical/arith), acc[W-1] (rotate), old carry (rotate-through-carry).
  - Right: carry <= acc[0]. Fill bit acc[W-1] <= 0 (logical), acc[W-1] (arith), acc[0] (rotate), old carry (rotate-through-carry).
- Any ld/sh_start strobe while busy=1 is ignored (acc unaffected) and ld_err pulses the following cycle.
- done and ld_err may both pulse in the same cycle.
- sh_start in the cycle done is high is legal (state is IDLE).

Decomposition:
- Package acc_pkg:
  - typedef enum logic {IDLE, SHIFT} acc_state_t
  - typedef enum logic [1:0] {SH_LOG, SH_ARI, SH_ROT, SH_RTC} sh_mode_t
  - localparams ACC_W=8, SH_W=3
- Sub-module acc_shift1: purely combinational 1-bit shifter.
  - Inputs: acc, carry, dir, mode.
  - Outputs: next acc and next carry.
  - Instantiated once; the FSM and registers remain in acc_shift_reg.

Test Plan:
- Reset: pulse rst_n low mid-cycle while in SHIFT -> acc=0x00, carry=0, busy=0, zero=1 immediately, without waiting for a clock edge.
- LUT load priority: lut_ld=1, lut_value=0x40, mem_ld=1, mem_data=0x11 -> next cycle acc=0x40, ld_err pulses 1, carry unchanged.
- ALU load: alu_ld, alu_result=0x00, alu_carry=1 -> acc=0x00, carry=1, zero=1.
- Logical left shift: acc=0x81, sh_start dir=0 mode=SH_LOG amt=3 -> busy high 3 cycles, acc=0x08, carry=0 (last bit out), done pulses once, 4 edges after accept.
- Arithmetic right with dropped load: acc=0x80, dir=1 mode=SH_ARI amt=2, lut_ld asserted mid-shift -> acc=0xE0, carry=0, neg=1, ld_err pulse, LUT value not loaded.
- Rotate-through-carry and zero amount:
  - carry=1, acc=0x00, dir=0 mode=SH_RTC amt=1 -> acc=0x01, carry=0.
  - Then amt=0 -> done pulses next cycle, busy never rises, acc stays 0x01.
